// File: rtl/commit_stage_pkg.sv
// Shared types and sizing for the commit/writeback stage.
// Holds the commit packet layout, the source enum and the popcount/lane-select helpers.
package commit_stage_pkg;

  localparam int ISSUE_WIDTH   = 1;
  localparam int NUM_WARPS     = 4;
  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int NUM_REGS      = 64;
  localparam int UUID_W        = 44;
  localparam int PC_W          = 32;
  localparam int PERF_CTR_BITS = 44;
  localparam bit EXT_F         = 1'b1;
  localparam bit EXT_T         = 1'b0;

  localparam int NW_BITS  = $clog2(NUM_WARPS);
  localparam int RD_BITS  = $clog2(NUM_REGS);
  localparam int NUM_SRC  = 5;
  localparam int SRC_BITS = $clog2(NUM_SRC);
  localparam int CNT_BITS = $clog2(NUM_THREADS + 1);

  typedef enum logic [SRC_BITS-1:0] {
    EX_ALU    = 3'd0,
    EX_LSU    = 3'd1,
    EX_FPU    = 3'd2,
    EX_SFU    = 3'd3,
    EX_TENSOR = 3'd4
  } src_e;

  // Bit per source in enum order; disabled units can never win arbitration.
  localparam logic [NUM_SRC-1:0] SRC_EN = {EXT_T, 1'b1, EXT_F, 1'b1, 1'b1};

  typedef struct packed {
    logic [UUID_W-1:0]                  uuid;
    logic [NW_BITS-1:0]                 wid;
    logic [NUM_THREADS-1:0]             tmask;
    logic [PC_W-1:0]                    pc;
    logic                               wb;
    logic [RD_BITS-1:0]                 rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]   data;
    logic                               sop;
    logic                               eop;
  } commit_pkt_t;

  typedef struct packed {
    logic [UUID_W-1:0]                  uuid;
    logic [NW_BITS-1:0]                 wid;
    logic [NUM_THREADS-1:0]             tmask;
    logic [PC_W-1:0]                    pc;
    logic [RD_BITS-1:0]                 rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]   data;
    logic                               sop;
    logic                               eop;
  } wb_pkt_t;

  function automatic logic [CNT_BITS-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [CNT_BITS-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) cnt = cnt + CNT_BITS'(mask[i]);
    return cnt;
  endfunction

  // Walk downward so the lowest active lane is the last one written.
  function automatic logic [XLEN-1:0] first_active_data(
    input logic [NUM_THREADS-1:0]           mask,
    input logic [NUM_THREADS-1:0][XLEN-1:0] lanes
  );
    logic [XLEN-1:0] val;
    val = lanes[0];
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask[i]) val = lanes[i];
    end
    return val;
  endfunction

endpackage

// File: rtl/commit_arb.sv
// Per-slot round-robin arbiter over the execution-unit streams with sop/eop lock,
// followed by the one-deep output register that always drains.
module commit_arb
  import commit_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        valid,
  input  commit_pkt_t [NUM_SRC-1:0] data,
  output logic [NUM_SRC-1:0]        ready,
  output logic                      commit_valid,
  output commit_pkt_t               commit_pkt
);

  logic [NUM_SRC-1:0]  req;
  logic [SRC_BITS-1:0] ptr;
  logic [SRC_BITS-1:0] lock_src;
  logic [SRC_BITS-1:0] grant_idx;
  logic [SRC_BITS-1:0] cand;
  logic [SRC_BITS-1:0] next_ptr;
  logic                locked;
  logic                any;
  logic                fire;

  assign req = valid & SRC_EN;

  // While a multi-packet instruction is in flight only its source may be granted.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    any       = 1'b0;
    if (locked) begin
      grant_idx = lock_src;
      any       = req[lock_src];
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cand = SRC_BITS'((int'(ptr) + i) % NUM_SRC);
        if (!any && req[cand]) begin
          any       = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign fire     = any & ~reset;
  assign ready    = fire ? (NUM_SRC'(1) << grant_idx) : '0;
  assign next_ptr = (grant_idx == SRC_BITS'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= EX_ALU;
      lock_src     <= EX_ALU;
      locked       <= 1'b0;
      commit_valid <= 1'b0;
      commit_pkt   <= '0;
    end else begin
      commit_valid <= fire;
      if (fire) begin
        commit_pkt <= data[grant_idx];
        ptr        <= next_ptr;
        lock_src   <= grant_idx;
        locked     <= ~data[grant_idx].eop;
      end
    end
  end

endmodule

// File: rtl/commit_stage.sv
// Commit/writeback stage: per-slot arbitration into writeback, plus the retired-thread
// counter, per-warp commit pulses and a simulation shadow of the register file.
module commit_stage
  import commit_stage_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic        [ISSUE_WIDTH-1:0]       alu_commit_valid,
  output logic        [ISSUE_WIDTH-1:0]       alu_commit_ready,
  input  commit_pkt_t [ISSUE_WIDTH-1:0]       alu_commit_data,
  input  logic        [ISSUE_WIDTH-1:0]       lsu_commit_valid,
  output logic        [ISSUE_WIDTH-1:0]       lsu_commit_ready,
  input  commit_pkt_t [ISSUE_WIDTH-1:0]       lsu_commit_data,
  input  logic        [ISSUE_WIDTH-1:0]       fpu_commit_valid,
  output logic        [ISSUE_WIDTH-1:0]       fpu_commit_ready,
  input  commit_pkt_t [ISSUE_WIDTH-1:0]       fpu_commit_data,
  input  logic        [ISSUE_WIDTH-1:0]       sfu_commit_valid,
  output logic        [ISSUE_WIDTH-1:0]       sfu_commit_ready,
  input  commit_pkt_t [ISSUE_WIDTH-1:0]       sfu_commit_data,
  input  logic        [ISSUE_WIDTH-1:0]       tensor_commit_valid,
  output logic        [ISSUE_WIDTH-1:0]       tensor_commit_ready,
  input  commit_pkt_t [ISSUE_WIDTH-1:0]       tensor_commit_data,
  output logic        [ISSUE_WIDTH-1:0]       wb_valid,
  output wb_pkt_t     [ISSUE_WIDTH-1:0]       wb_data,
  output logic        [PERF_CTR_BITS-1:0]     csr_instret,
  output logic        [NUM_WARPS-1:0]         sched_committed_warps,
  output logic        [NUM_REGS-1:0][XLEN-1:0] sim_wb_value
);

  logic        [NUM_SRC-1:0] src_valid [ISSUE_WIDTH];
  logic        [NUM_SRC-1:0] src_ready [ISSUE_WIDTH];
  commit_pkt_t [NUM_SRC-1:0] src_data  [ISSUE_WIDTH];
  logic        [ISSUE_WIDTH-1:0] commit_valid;
  commit_pkt_t                   commit_pkt [ISSUE_WIDTH];

  logic [PERF_CTR_BITS-1:0] retire_cnt;
  logic [NUM_WARPS-1:0]     warp_hits;

  for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
    assign src_valid[s] = {tensor_commit_valid[s], sfu_commit_valid[s], fpu_commit_valid[s],
                           lsu_commit_valid[s], alu_commit_valid[s]};
    assign src_data[s][EX_ALU]    = alu_commit_data[s];
    assign src_data[s][EX_LSU]    = lsu_commit_data[s];
    assign src_data[s][EX_FPU]    = fpu_commit_data[s];
    assign src_data[s][EX_SFU]    = sfu_commit_data[s];
    assign src_data[s][EX_TENSOR] = tensor_commit_data[s];

    assign alu_commit_ready[s]    = src_ready[s][EX_ALU];
    assign lsu_commit_ready[s]    = src_ready[s][EX_LSU];
    assign fpu_commit_ready[s]    = src_ready[s][EX_FPU];
    assign sfu_commit_ready[s]    = src_ready[s][EX_SFU];
    assign tensor_commit_ready[s] = src_ready[s][EX_TENSOR];

    commit_arb u_arb (
      .clk          (clk),
      .reset        (reset),
      .valid        (src_valid[s]),
      .data         (src_data[s]),
      .ready        (src_ready[s]),
      .commit_valid (commit_valid[s]),
      .commit_pkt   (commit_pkt[s])
    );

    assign wb_valid[s]      = commit_valid[s] & commit_pkt[s].wb;
    assign wb_data[s].uuid  = commit_pkt[s].uuid;
    assign wb_data[s].wid   = commit_pkt[s].wid;
    assign wb_data[s].tmask = commit_pkt[s].tmask;
    assign wb_data[s].pc    = commit_pkt[s].pc;
    assign wb_data[s].rd    = commit_pkt[s].rd;
    assign wb_data[s].data  = commit_pkt[s].data;
    assign wb_data[s].sop   = commit_pkt[s].sop;
    assign wb_data[s].eop   = commit_pkt[s].eop;
  end

  // Only the closing packet of an instruction retires threads and signals the warp.
  always_comb begin
    retire_cnt = '0;
    warp_hits  = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      if (commit_valid[s] && commit_pkt[s].eop) begin
        retire_cnt = retire_cnt + PERF_CTR_BITS'(popcount(commit_pkt[s].tmask));
        warp_hits[commit_pkt[s].wid] = 1'b1;
      end
    end
  end

  // Ascending slot order lets the higher slot win a same-rd collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_instret           <= '0;
      sched_committed_warps <= '0;
      sim_wb_value          <= '0;
    end else begin
      csr_instret           <= csr_instret + retire_cnt;
      sched_committed_warps <= warp_hits;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (wb_valid[s] && commit_pkt[s].rd != '0)
          sim_wb_value[commit_pkt[s].rd] <= first_active_data(commit_pkt[s].tmask, commit_pkt[s].data);
      end
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: latency, round-robin order, sop/eop lock,
// retire counting, register shadow and mid-packet reset.
module tb_commit_stage;
  import commit_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        [ISSUE_WIDTH-1:0] alu_commit_valid, lsu_commit_valid, fpu_commit_valid;
  logic        [ISSUE_WIDTH-1:0] sfu_commit_valid, tensor_commit_valid;
  logic        [ISSUE_WIDTH-1:0] alu_commit_ready, lsu_commit_ready, fpu_commit_ready;
  logic        [ISSUE_WIDTH-1:0] sfu_commit_ready, tensor_commit_ready;
  commit_pkt_t [ISSUE_WIDTH-1:0] alu_commit_data, lsu_commit_data, fpu_commit_data;
  commit_pkt_t [ISSUE_WIDTH-1:0] sfu_commit_data, tensor_commit_data;
  logic        [ISSUE_WIDTH-1:0] wb_valid;
  wb_pkt_t     [ISSUE_WIDTH-1:0] wb_data;
  logic        [PERF_CTR_BITS-1:0] csr_instret;
  logic        [NUM_WARPS-1:0]     sched_committed_warps;
  logic        [NUM_REGS-1:0][XLEN-1:0] sim_wb_value;

  int total = 0;
  int bad   = 0;

  commit_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .alu_commit_valid      (alu_commit_valid),
    .alu_commit_ready      (alu_commit_ready),
    .alu_commit_data       (alu_commit_data),
    .lsu_commit_valid      (lsu_commit_valid),
    .lsu_commit_ready      (lsu_commit_ready),
    .lsu_commit_data       (lsu_commit_data),
    .fpu_commit_valid      (fpu_commit_valid),
    .fpu_commit_ready      (fpu_commit_ready),
    .fpu_commit_data       (fpu_commit_data),
    .sfu_commit_valid      (sfu_commit_valid),
    .sfu_commit_ready      (sfu_commit_ready),
    .sfu_commit_data       (sfu_commit_data),
    .tensor_commit_valid   (tensor_commit_valid),
    .tensor_commit_ready   (tensor_commit_ready),
    .tensor_commit_data    (tensor_commit_data),
    .wb_valid              (wb_valid),
    .wb_data               (wb_data),
    .csr_instret           (csr_instret),
    .sched_committed_warps (sched_committed_warps),
    .sim_wb_value          (sim_wb_value)
  );

  // Lane t carries d0 + t so the lowest-active-lane pick is observable.
  function automatic commit_pkt_t mk_pkt(input logic [UUID_W-1:0] uuid, input logic [NW_BITS-1:0] wid,
                                         input logic [NUM_THREADS-1:0] tmask, input logic wb,
                                         input logic [RD_BITS-1:0] rd, input logic [XLEN-1:0] d0,
                                         input logic sop, input logic eop);
    commit_pkt_t p;
    p       = '0;
    p.uuid  = uuid;
    p.wid   = wid;
    p.tmask = tmask;
    p.pc    = PC_W'(32'h8000_0000);
    p.wb    = wb;
    p.rd    = rd;
    for (int t = 0; t < NUM_THREADS; t++) p.data[t] = d0 + XLEN'(t);
    p.sop   = sop;
    p.eop   = eop;
    return p;
  endfunction

  task automatic idle_all();
    alu_commit_valid = '0; lsu_commit_valid = '0; fpu_commit_valid = '0;
    sfu_commit_valid = '0; tensor_commit_valid = '0;
    alu_commit_data = '0; lsu_commit_data = '0; fpu_commit_data = '0;
    sfu_commit_data = '0; tensor_commit_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] rdy;
    reset = 1'b1;
    alu_commit_valid = '1; lsu_commit_valid = '1; fpu_commit_valid = '1;
    sfu_commit_valid = '1; tensor_commit_valid = '1;
    alu_commit_data[0] = mk_pkt(44'h1, 2'd1, 4'hF, 1'b1, 6'd3, 32'h11, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rdy = {tensor_commit_ready[0], sfu_commit_ready[0], fpu_commit_ready[0], lsu_commit_ready[0], alu_commit_ready[0]};
    total++; if (rdy !== 5'b0) begin bad++; $display("FAIL reset_ready: got %b want 00000", rdy); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
    total++; if (csr_instret !== '0) begin bad++; $display("FAIL reset_instret: got %0d want 0", csr_instret); end
    total++; if (sched_committed_warps !== 4'b0) begin bad++; $display("FAIL reset_warps: got %b want 0000", sched_committed_warps); end
    total++; if (sim_wb_value !== '0) begin bad++; $display("FAIL reset_sim: got any_set=%b want 0", |sim_wb_value); end
    idle_all();
    reset = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_commit_valid[0] = 1'b1;
    alu_commit_data[0]  = mk_pkt(44'h42, 2'd2, 4'b1011, 1'b1, 6'd5, 32'h1234, 1'b1, 1'b1);
    #1;
    total++; if (alu_commit_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", alu_commit_ready); end
    @(posedge clk); #1;
    alu_commit_valid[0] = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_wb_valid: got %b want 1", wb_valid); end
    total++; if (wb_data[0].rd !== 6'd5 || wb_data[0].uuid !== 44'h42 || wb_data[0].tmask !== 4'b1011 || wb_data[0].wid !== 2'd2)
      begin bad++; $display("FAIL single_wb_fields: got rd=%0d uuid=%0h tmask=%b wid=%0d want rd=5 uuid=42 tmask=1011 wid=2",
        wb_data[0].rd, wb_data[0].uuid, wb_data[0].tmask, wb_data[0].wid); end
    total++; if (wb_data[0].data[0] !== 32'h1234) begin bad++; $display("FAIL single_wb_data: got %0h want 1234", wb_data[0].data[0]); end
    total++; if (sched_committed_warps !== 4'b0 || csr_instret !== '0)
      begin bad++; $display("FAIL single_early: got warps=%b instret=%0d want 0000/0", sched_committed_warps, csr_instret); end
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_drop: got %b want 0", wb_valid); end
    total++; if (sched_committed_warps !== 4'b0100) begin bad++; $display("FAIL single_warps: got %b want 0100", sched_committed_warps); end
    total++; if (csr_instret !== 44'd3) begin bad++; $display("FAIL single_instret: got %0d want 3", csr_instret); end
    total++; if (sim_wb_value[5] !== 32'h1234) begin bad++; $display("FAIL single_sim: got %0h want 1234", sim_wb_value[5]); end
    @(posedge clk); #1;
    total++; if (sched_committed_warps !== 4'b0) begin bad++; $display("FAIL single_pulse_len: got %b want 0000", sched_committed_warps); end
    total++; if (csr_instret !== 44'd3) begin bad++; $display("FAIL single_instret_hold: got %0d want 3", csr_instret); end
  endtask

  task automatic test_round_robin();
    logic [2:0]        exp_rdy [6];
    logic [UUID_W-1:0] exp_uuid [6];
    logic [2:0]        rdy;
    exp_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_uuid = '{44'h1, 44'h2, 44'h4, 44'h1, 44'h2, 44'h4};
    do_reset();
    alu_commit_valid[0] = 1'b1; alu_commit_data[0] = mk_pkt(44'h1, 2'd0, 4'h1, 1'b1, 6'd1, 32'h10, 1'b1, 1'b1);
    lsu_commit_valid[0] = 1'b1; lsu_commit_data[0] = mk_pkt(44'h2, 2'd1, 4'h1, 1'b1, 6'd2, 32'h20, 1'b1, 1'b1);
    sfu_commit_valid[0] = 1'b1; sfu_commit_data[0] = mk_pkt(44'h4, 2'd3, 4'h1, 1'b1, 6'd4, 32'h40, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      rdy = {sfu_commit_ready[0], lsu_commit_ready[0], alu_commit_ready[0]};
      total++; if (rdy !== exp_rdy[c] || fpu_commit_ready !== 1'b0)
        begin bad++; $display("FAIL rr_grant[%0d]: got sfu/lsu/alu=%b fpu=%b want %b fpu=0", c, rdy, fpu_commit_ready, exp_rdy[c]); end
      if (c > 0) begin
        total++; if (wb_data[0].uuid !== exp_uuid[c-1] || wb_valid !== 1'b1)
          begin bad++; $display("FAIL rr_wb[%0d]: got uuid=%0h valid=%b want uuid=%0h valid=1", c, wb_data[0].uuid, wb_valid, exp_uuid[c-1]); end
      end
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  task automatic test_multi_packet();
    logic [1:0] exp_rdy   [7];
    logic [3:0] exp_warps [7];
    logic [1:0] rdy;
    exp_rdy   = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    exp_warps = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          alu_commit_valid[0] = 1'b1; alu_commit_data[0] = mk_pkt(44'h10, 2'd0, 4'b0001, 1'b1, 6'd1, 32'h100, 1'b1, 1'b1);
          lsu_commit_valid[0] = 1'b1; lsu_commit_data[0] = mk_pkt(44'h20, 2'd1, 4'b1111, 1'b1, 6'd7, 32'h200, 1'b1, 1'b0);
        end
        2: lsu_commit_data[0] = mk_pkt(44'h21, 2'd1, 4'b0011, 1'b1, 6'd7, 32'h300, 1'b0, 1'b1);
        3: lsu_commit_valid[0] = 1'b0;
        4: alu_commit_valid[0] = 1'b0;
        default: ;
      endcase
      #1;
      rdy = {lsu_commit_ready[0], alu_commit_ready[0]};
      total++; if (rdy !== exp_rdy[c]) begin bad++; $display("FAIL lock_grant[%0d]: got lsu/alu=%b want %b", c, rdy, exp_rdy[c]); end
      total++; if (sched_committed_warps !== exp_warps[c])
        begin bad++; $display("FAIL lock_warps[%0d]: got %b want %b", c, sched_committed_warps, exp_warps[c]); end
      if (c == 3) begin
        total++; if (csr_instret !== 44'd1) begin bad++; $display("FAIL lock_instret_mid: got %0d want 1", csr_instret); end
      end
      if (c == 6) begin
        total++; if (csr_instret !== 44'd4) begin bad++; $display("FAIL lock_instret_end: got %0d want 4", csr_instret); end
      end
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  task automatic test_no_writeback();
    do_reset();
    alu_commit_valid[0] = 1'b1;
    alu_commit_data[0]  = mk_pkt(44'h55, 2'd3, 4'hF, 1'b0, 6'd9, 32'hAAAA, 1'b1, 1'b1);
    @(posedge clk); #1;
    alu_commit_valid[0] = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL nowb_wb_valid: got %b want 0", wb_valid); end
    @(posedge clk); #1;
    total++; if (csr_instret !== 44'd4) begin bad++; $display("FAIL nowb_instret: got %0d want 4", csr_instret); end
    total++; if (sched_committed_warps !== 4'b1000) begin bad++; $display("FAIL nowb_warps: got %b want 1000", sched_committed_warps); end
    total++; if (sim_wb_value[9] !== 32'h0) begin bad++; $display("FAIL nowb_sim: got %0h want 0", sim_wb_value[9]); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_commit_valid[0] = 1'b1;
    alu_commit_data[0]  = mk_pkt(44'h60, 2'd0, 4'b0001, 1'b1, 6'd0, 32'hFFFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    alu_commit_data[0]  = mk_pkt(44'h61, 2'd0, 4'b1100, 1'b1, 6'd3, 32'hDEAD_0000, 1'b1, 1'b1);
    total++; if (wb_valid !== 1'b1 || wb_data[0].rd !== 6'd0)
      begin bad++; $display("FAIL rd0_wb: got valid=%b rd=%0d want valid=1 rd=0", wb_valid, wb_data[0].rd); end
    @(posedge clk); #1;
    alu_commit_valid[0] = 1'b0;
    total++; if (sim_wb_value[0] !== 32'h0) begin bad++; $display("FAIL rd0_sim: got %0h want 0", sim_wb_value[0]); end
    @(posedge clk); #1;
    total++; if (sim_wb_value[3] !== 32'hDEAD_0002) begin bad++; $display("FAIL lane_pick_sim: got %0h want dead0002", sim_wb_value[3]); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    alu_commit_valid[0] = 1'b1;
    alu_commit_data[0]  = mk_pkt(44'h70, 2'd1, 4'hF, 1'b1, 6'd4, 32'h55, 1'b1, 1'b1);
    @(posedge clk); #1;
    alu_commit_valid[0] = 1'b0;
    lsu_commit_valid[0] = 1'b1;
    lsu_commit_data[0]  = mk_pkt(44'h71, 2'd2, 4'hF, 1'b1, 6'd6, 32'h66, 1'b1, 1'b0);
    #1;
    total++; if (lsu_commit_ready !== 1'b1) begin bad++; $display("FAIL mid_lsu_grant: got %b want 1", lsu_commit_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    lsu_commit_data[0]  = mk_pkt(44'h72, 2'd2, 4'hF, 1'b1, 6'd6, 32'h77, 1'b0, 1'b1);
    alu_commit_valid[0] = 1'b1;
    #1;
    total++; if (alu_commit_ready !== 1'b0 || lsu_commit_ready !== 1'b0)
      begin bad++; $display("FAIL mid_ready_in_reset: got alu=%b lsu=%b want 0/0", alu_commit_ready, lsu_commit_ready); end
    total++; if (csr_instret !== 44'd4 || sched_committed_warps !== 4'b0010 || sim_wb_value[4] !== 32'h55)
      begin bad++; $display("FAIL mid_pre_reset: got instret=%0d warps=%b sim4=%0h want 4/0010/55",
        csr_instret, sched_committed_warps, sim_wb_value[4]); end
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (wb_valid !== 1'b0 || wb_data !== '0)
      begin bad++; $display("FAIL mid_wb_cleared: got valid=%b data=%0h want 0/0", wb_valid, wb_data); end
    total++; if (csr_instret !== '0 || sched_committed_warps !== 4'b0)
      begin bad++; $display("FAIL mid_ctr_cleared: got instret=%0d warps=%b want 0/0000", csr_instret, sched_committed_warps); end
    total++; if (sim_wb_value !== '0) begin bad++; $display("FAIL mid_sim_cleared: got any_set=%b want 0", |sim_wb_value); end
    lsu_commit_valid[0] = 1'b0;
    sfu_commit_valid[0] = 1'b1;
    sfu_commit_data[0]  = mk_pkt(44'h73, 2'd0, 4'h1, 1'b1, 6'd2, 32'h88, 1'b1, 1'b1);
    #1;
    total++; if (alu_commit_ready !== 1'b1 || sfu_commit_ready !== 1'b0 || lsu_commit_ready !== 1'b0)
      begin bad++; $display("FAIL mid_restart_alu: got alu=%b sfu=%b lsu=%b want 1/0/0",
        alu_commit_ready, sfu_commit_ready, lsu_commit_ready); end
    idle_all();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_single_alu();
    test_round_robin();
    test_multi_packet();
    test_no_writeback();
    test_rd_zero();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
